// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and mode codes for the NTT stage sequencer
// and its twiddle address generator.
package ntt_pkg;

   localparam int LOGN = 10;                 // log2 of the polynomial length
   localparam int N    = 1 << LOGN;          // polynomial length
   localparam int GW   = LOGN - 3;           // group index width (N/8 groups of 4 butterflies)
   localparam int TW_W = LOGN + 1;           // twiddle ROM address width (2N entries)

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic MODE_NTT  = 1'b0;
   localparam logic MODE_INTT = 1'b1;

   // Inverse twiddles live in the upper half of the ROM
   localparam logic [TW_W-1:0] INTT_TW_OFFSET = TW_W'(N);
   localparam logic [TW_W-1:0] TW_ONE         = TW_W'(1);

endpackage

// File: rtl/ntt_tw_addr_gen.sv
// Combinational twiddle ROM address generator for the 4 butterfly lanes of
// one group. Lane i handles butterfly k = 4*group + i.
module ntt_tw_addr_gen
   import ntt_pkg::*;
(
   input  logic [3:0]        stage,
   input  logic [GW-1:0]     group,
   input  logic              mode,
   output logic [4*TW_W-1:0] tw_addr
);

   logic [3:0] shift;

   assign shift = 4'(LOGN - 1) - stage;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [TW_W-1:0] k_val;
         logic [TW_W-1:0] tw;

         // Address = 2^s + (k >> (LOGN-1-s)), shifted into the inverse half for INTT
         always_comb begin
            k_val = {2'b00, group, 2'(gi)};
            tw    = (TW_ONE << stage) + (k_val >> shift);
            if (mode == MODE_INTT) begin
               tw = tw + INTT_TW_OFFSET;
            end
         end

         assign tw_addr[gi*TW_W +: TW_W] = tw;
      end
   endgenerate

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Stage sequencer for the radix-2, 4-BFU NTT datapath. One start walks every
// stage (forward: 0..LOGN-1, inverse: LOGN-1..0), issuing one group of four
// butterflies per cycle, draining the BFU pipeline between stages.
// Optional build macro NTT_STAGE_CTRL_PERF_EN adds a 32-bit busy-cycle counter
// on port cycle_cnt.
module ntt_stage_ctrl
   import ntt_pkg::*;
#(
   parameter int PIPE_LAT = 6                // rd_en to wr_en latency, 1..15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [GW-1:0]     rd_group,
   output logic [3:0]        rd_stage,
   output logic [4*TW_W-1:0] tw_addr,
   output logic              wr_en,
   output logic [GW-1:0]     wr_group,
   output logic [3:0]        wr_stage
`ifdef NTT_STAGE_CTRL_PERF_EN
   ,
   output logic [31:0]       cycle_cnt
`endif
);

   localparam logic [GW-1:0] LAST_GROUP = '1;
   localparam logic [3:0]    LAST_DRAIN = 4'(PIPE_LAT - 1);
   localparam logic [3:0]    LAST_STAGE = 4'(LOGN - 1);

   state_t              state_reg, state_next;
   logic                mode_reg, mode_next;
   logic [3:0]          stage_reg, stage_next;
   logic [GW-1:0]       group_reg, group_next;
   logic [3:0]          drain_reg, drain_next;
   logic [4*TW_W-1:0]   tw_reg, tw_next;
   logic                is_last_stage;

   // Twiddles are computed from next-cycle indices so the registered address
   // lines up with the rd_en it belongs to.
   ntt_tw_addr_gen u_tw_gen (
      .stage   (stage_next),
      .group   (group_next),
      .mode    (mode_next),
      .tw_addr (tw_next)
   );

   // Sequencer state and registered twiddle addresses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         mode_reg  <= MODE_NTT;
         stage_reg <= '0;
         group_reg <= '0;
         drain_reg <= '0;
         tw_reg    <= '0;
      end else begin
         state_reg <= state_next;
         mode_reg  <= mode_next;
         stage_reg <= stage_next;
         group_reg <= group_next;
         drain_reg <= drain_next;
         tw_reg    <= tw_next;
      end
   end

   // Next-state logic: issue groups, drain, step stage, finish
   always_comb begin
      state_next    = state_reg;
      mode_next     = mode_reg;
      stage_next    = stage_reg;
      group_next    = group_reg;
      drain_next    = drain_reg;
      is_last_stage = (mode_reg == MODE_NTT) ? (stage_reg == LAST_STAGE) : (stage_reg == 4'd0);

      case (state_reg)
         IDLE: begin
            if (start) begin
               mode_next  = mode;
               stage_next = (mode == MODE_NTT) ? 4'd0 : LAST_STAGE;
               group_next = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            group_next = group_reg + 1'b1;
            if (group_reg == LAST_GROUP) begin
               drain_next = '0;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_reg == LAST_DRAIN) begin
               if (is_last_stage) begin
                  state_next = DONE;
               end else begin
                  stage_next = (mode_reg == MODE_NTT) ? stage_reg + 4'd1 : stage_reg - 4'd1;
                  group_next = '0;
                  state_next = RUN;
               end
            end else begin
               drain_next = drain_reg + 4'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy     = (state_reg != IDLE);
   assign done     = (state_reg == DONE);
   assign rd_en    = (state_reg == RUN);
   assign rd_group = group_reg;
   assign rd_stage = stage_reg;
   assign tw_addr  = tw_reg;

   // Write-side delay line mirroring the BFU pipeline
   logic [PIPE_LAT-1:0] dl_en_reg;
   logic [GW-1:0]       dl_group_reg [PIPE_LAT];
   logic [3:0]          dl_stage_reg [PIPE_LAT];

   genvar gi;
   generate
      for (gi = 0; gi < PIPE_LAT; gi++) begin : g_dl
         if (gi == 0) begin : g_first
            // First tap captures the issued read
            always_ff @(posedge clk) begin
               if (rst) begin
                  dl_en_reg[0]    <= 1'b0;
                  dl_group_reg[0] <= '0;
                  dl_stage_reg[0] <= '0;
               end else begin
                  dl_en_reg[0]    <= rd_en;
                  dl_group_reg[0] <= rd_group;
                  dl_stage_reg[0] <= rd_stage;
               end
            end
         end else begin : g_rest
            // Later taps shift the previous tap along
            always_ff @(posedge clk) begin
               if (rst) begin
                  dl_en_reg[gi]    <= 1'b0;
                  dl_group_reg[gi] <= '0;
                  dl_stage_reg[gi] <= '0;
               end else begin
                  dl_en_reg[gi]    <= dl_en_reg[gi-1];
                  dl_group_reg[gi] <= dl_group_reg[gi-1];
                  dl_stage_reg[gi] <= dl_stage_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   assign wr_en    = dl_en_reg[PIPE_LAT-1];
   assign wr_group = dl_group_reg[PIPE_LAT-1];
   assign wr_stage = dl_stage_reg[PIPE_LAT-1];

`ifdef NTT_STAGE_CTRL_PERF_EN
   logic [31:0] cycle_cnt_reg;

   // Busy-cycle counter: cleared by an accepted start, frozen while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_reg <= '0;
      end else if (state_reg == IDLE && start) begin
         cycle_cnt_reg <= '0;
      end else if (state_reg != IDLE) begin
         cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      end
   end

   assign cycle_cnt = cycle_cnt_reg;
`endif

endmodule

// File: doc/ntt_stage_ctrl.md
Name: ntt_stage_ctrl

Overview:
- Sequencer for the radix-2, 4-BFU NTT datapath in top_poly_mul.
- On one start strobe it walks all LOGN stages of a forward NTT (Cooley-Tukey) or an inverse NTT (Gentleman-Sande).
- Each cycle it issues one group of 4 consecutive butterflies: read strobe, group/stage tags and 4 twiddle ROM addresses.
- It issues delayed write strobes matched to the BFU pipeline, inserts a drain between stages, and pulses done at the end.

Parameters:
- LOGN, 10, log2 of the polynomial length (N = 1024).
- PIPE_LAT, 6, cycles from rd_en to the matching wr_en (bank read + BFU + writeback); legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = NTT, 1 = INTT; latched with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the transform is complete
- rd_en  out  1  read/issue strobe for one butterfly group
- rd_group  out  LOGN-3  group index g; butterflies k = 4g..4g+3
- rd_stage  out  4  stage currently issued
- tw_addr  out  4*(LOGN+1)  twiddle ROM addresses; lane i in bits [(i+1)(LOGN+1)-1 : i(LOGN+1)]
- wr_en  out  1  write strobe, rd_en delayed PIPE_LAT cycles
- wr_group  out  LOGN-3  rd_group delayed PIPE_LAT cycles
- wr_stage  out  4  rd_stage delayed PIPE_LAT cycles

Behaviour:
- Reset values: all outputs 0; state IDLE; delay line cleared.
- States:
  - IDLE: on start, latch mode. Set stage to 0 for NTT or LOGN-1 for INTT; set g = 0; go to RUN.
  - RUN: assert rd_en and increment g each cycle. After g = N/8-1 (128 cycles), go to DRAIN.
  - DRAIN: hold PIPE_LAT cycles with rd_en = 0. Then, if the last stage is done (stage LOGN-1 for NTT, stage 0 for INTT), go to DONE. Otherwise step stage (+1 for NTT, -1 for INTT), set g = 0 and return to RUN.
  - DONE: done = 1 for one cycle, then IDLE.
- The drain guarantees every write of stage s completes before any read of stage s+1. The datapath needs no extra hazard logic.
- Butterfly pairing, for the datapath's reference only:
  - d = N >> (s+1)
  - top = ((k >> (LOGN-1-s)) << (LOGN-s)) | (k & (d-1))
  - bottom = top + d
- Twiddle address for lane i, with k = 4g+i:
  - NTT: tw = (1 << s) + (k >> (LOGN-1-s))
  - INTT: tw = N + (1 << s) + (k >> (LOGN-1-s))
  - The ROM holds 2N entries. Addresses are registered, aligned with rd_en.
- Delay line: PIPE_LAT-deep shift register of {rd_en, rd_group, rd_stage}. wr_* is valid exactly PIPE_LAT cycles after the matching rd_*.
- Timing, with start accepted in cycle 0:
  - Reads run in cycles 1..128 and drain in 129..128+PIPE_LAT.
  - Each stage lasts 128+PIPE_LAT cycles.
  - done is asserted in cycle 1 + LOGN*(128+PIPE_LAT): 1341 for the defaults.
  - busy is high in cycles 1..1341.
- Boundary cases:
  - start while busy: ignored.
  - mode changes mid-operation: no effect.
  - rst mid-operation: next cycle IDLE, delay line flushed. No wr_en is emitted after reset, even if reads were in flight.
  - start in the DONE cycle: ignored. A new start is accepted from IDLE on the following cycle.

Optional Feature:
- Macro NTT_STAGE_CTRL_PERF_EN.
- Defined: adds output port cycle_cnt (32 bits). It clears on an accepted start, increments every busy cycle, and holds its value after done until the next start (1341 after a default run).
- Undefined: no port, no counter logic.

Decomposition:
- Shared package ntt_pkg:
  - constants LOGN and N
  - state encoding IDLE/RUN/DRAIN/DONE
  - mode codes MODE_NTT = 0, MODE_INTT = 1
  - function or constant for the INTT twiddle offset (N)
- Sub-module ntt_tw_addr_gen: combinational. Takes stage, group and mode; produces the 4 lane twiddle addresses. It is instantiated once and its output registered in ntt_stage_ctrl.

Test Plan:
- NTT run: pulse start with mode = 0.
  - Stage 0: group 5 gives tw lanes = 1,1,1,1.
  - Stage 9: group 5 gives tw = 532,533,534,535.
  - Exactly 1280 rd_en and 1280 wr_en pulses; done in cycle 1341.
- INTT run with mode = 1: the first issued stage is 9 and group 0 gives tw = 1536,1537,1538,1539. Stage 0 gives tw = 1025 for all lanes. The last rd_stage is 0.
- Latency check: every wr_en/wr_group/wr_stage equals rd_* from exactly 6 cycles earlier. At stage transitions, a 6-cycle rd_en-low gap appears and the first read of stage s+1 follows the last write of stage s.
- Reset mid-operation: assert rst at cycle 200. busy = 0 and wr_en = 0 from cycle 201 onward; a new start at cycle 205 completes normally.
- start pulses at cycles 50 and 1341 during a run: both ignored, a single done occurs, and rd_en count stays 1280.
- With NTT_STAGE_CTRL_PERF_EN defined: cycle_cnt reads 1341 after a default NTT run and clears on the next start.
